// File: rtl/exe_stage_div.sv
// Execute stage: latches decode-stage operands, feeds the external ALU, runs a
// 32-iteration restoring divider for div/mod ops, issues the data-SRAM request
// for loads/stores and flags address misalignment (ALE) in es2ms_except[6].
// Optional feature macro: DIV_ZERO_FAST_EN (divide-by-zero skips the iterations).
module exe_stage_div (
    input  logic        clk,
    input  logic        reset,
    output logic        es_allowin,
    input  logic        ds2es_valid,
    input  logic [31:0] ds_pc,
    input  logic [31:0] ds_src1,
    input  logic [31:0] ds_src2,
    input  logic [11:0] ds_alu_op,
    input  logic [3:0]  ds_div_op,
    input  logic [4:0]  ds_ld_op,
    input  logic [2:0]  ds_st_op,
    input  logic [6:0]  ds_rf_ctl,
    input  logic [31:0] ds_st_data,
    input  logic [6:0]  ds_except_zip,
    output logic [31:0] es_src1,
    output logic [31:0] es_src2,
    output logic [11:0] es_alu_op,
    input  logic [31:0] alu_result,
    input  logic        ms_allowin,
    output logic        es2ms_valid,
    output logic [4:0]  es2ms_ld_op,
    output logic [31:0] es2ms_pc,
    output logic [6:0]  es2ms_except,
    output logic [39:0] es_rf_zip,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_we,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic        ms_ex,
    input  logic        wb_ex
);

    localparam int DIV_ITER = 32;

    typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_DONE} div_state_t;

    logic        es_valid;
    logic        es_ready_go;
    logic [3:0]  div_op;
    logic [2:0]  st_op;
    logic [6:0]  rf_ctl;
    logic [31:0] st_data;
    logic [6:0]  except_r;

    div_state_t  div_state;
    logic [4:0]  div_cnt;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] dsr;
    logic        neg_q;
    logic        neg_r;
    logic        dzero;

    logic        is_div;
    logic        div_signed;
    logic [31:0] abs1;
    logic [31:0] abs2;
    logic [32:0] trial;
    logic [32:0] diff;
    logic        step_bit;
    logic [31:0] step_rem;
    logic [31:0] q_fix;
    logic [31:0] r_fix;
    logic [31:0] div_result;
    logic [31:0] rf_wdata;
    logic        ale;
    logic        sram_go;
    logic [3:0]  st_we;

    assign is_div      = |div_op;
    assign div_signed  = div_op[3] | div_op[1];
    assign es_ready_go = ~is_div | (div_state == DIV_DONE);
    assign es_allowin  = ~es_valid | (es_ready_go & ms_allowin);
    assign es2ms_valid = es_valid & es_ready_go;

    // Pipeline valid bit and latched payload; a WB flush empties the stage.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values of its neighbours.
        if (reset) begin
            es_valid     <= 1'b0;
            es2ms_pc     <= '0;
            es_src1      <= '0;
            es_src2      <= '0;
            es_alu_op    <= '0;
            div_op       <= '0;
            es2ms_ld_op  <= '0;
            st_op        <= '0;
            rf_ctl       <= '0;
            st_data      <= '0;
            except_r     <= '0;
        end else begin
            if (wb_ex) begin
                es_valid <= 1'b0;
            end else if (es_allowin) begin
                es_valid <= ds2es_valid;
            end
            if (ds2es_valid && es_allowin) begin
                es2ms_pc    <= ds_pc;
                es_src1     <= ds_src1;
                es_src2     <= ds_src2;
                es_alu_op   <= ds_alu_op;
                div_op      <= ds_div_op;
                es2ms_ld_op <= ds_ld_op;
                st_op       <= ds_st_op;
                rf_ctl      <= ds_rf_ctl;
                st_data     <= ds_st_data;
                except_r    <= ds_except_zip;
            end
        end
    end

    // Divider operands are magnitudes; signs are reapplied on the way out.
    assign abs1     = (div_signed && es_src1[31]) ? -es_src1 : es_src1;
    assign abs2     = (div_signed && es_src2[31]) ? -es_src2 : es_src2;
    assign trial    = {rem, quo[31]};
    assign diff     = trial - {1'b0, dsr};
    assign step_bit = (trial >= {1'b0, dsr});
    assign step_rem = step_bit ? diff[31:0] : trial[31:0];

    // Divider FSM: one restoring iteration per CALC cycle, result held in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_state <= DIV_IDLE;
            div_cnt   <= '0;
            rem       <= '0;
            quo       <= '0;
            dsr       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            dzero     <= 1'b0;
        end else if (wb_ex) begin
            div_state <= DIV_IDLE;
            div_cnt   <= '0;
        end else begin
            case (div_state)
                DIV_IDLE: begin
                    if (es_valid && is_div) begin
                        neg_q   <= div_signed & (es_src1[31] ^ es_src2[31]);
                        neg_r   <= div_signed & es_src1[31];
                        dzero   <= (es_src2 == 32'd0);
                        rem     <= '0;
                        quo     <= abs1;
                        dsr     <= abs2;
                        div_cnt <= '0;
`ifdef DIV_ZERO_FAST_EN
                        if (es_src2 == 32'd0) begin
                            rem       <= abs1;
                            quo       <= '1;
                            div_state <= DIV_DONE;
                        end else begin
                            div_state <= DIV_CALC;
                        end
`else
                        div_state <= DIV_CALC;
`endif
                    end
                end
                DIV_CALC: begin
                    rem     <= step_rem;
                    quo     <= {quo[30:0], step_bit};
                    div_cnt <= div_cnt + 5'd1;
                    if (div_cnt == 5'(DIV_ITER - 1)) begin
                        div_state <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    if (es2ms_valid && ms_allowin) begin
                        div_state <= DIV_IDLE;
                    end
                end
                default: div_state <= DIV_IDLE;
            endcase
        end
    end

    // Division by zero yields all-ones quotient; remainder falls out as the dividend.
    assign q_fix      = dzero ? 32'hFFFF_FFFF : (neg_q ? -quo : quo);
    assign r_fix      = neg_r ? -rem : rem;
    assign div_result = (div_op[3] | div_op[2]) ? q_fix : r_fix;
    assign rf_wdata   = is_div ? div_result : alu_result;

    assign es_rf_zip    = {rf_ctl[6] & es_valid, |es2ms_ld_op, rf_ctl[5] & es_valid,
                           rf_ctl[4:0], rf_wdata};
    assign es2ms_except = {ale, except_r[5:0]};

    // Memory request: issued only on the handoff cycle so a stall never repeats it.
    assign ale = ((es2ms_ld_op[2] | es2ms_ld_op[1] | st_op[1]) & alu_result[0])
               | ((es2ms_ld_op[0] | st_op[0]) & (alu_result[1:0] != 2'b00));
    assign sram_go = es_valid & es_ready_go & ms_allowin
                   & ((|es2ms_ld_op) | (|st_op))
                   & ~ale & ~ms_ex & ~wb_ex & ~(|except_r);

    // Byte-lane enables and replicated store data for the addressed lanes.
    always_comb begin
        // NOTE: defaults first so every path assigns these and no latch is inferred.
        st_we           = 4'b0000;
        data_sram_wdata = st_data;
        if (st_op[2]) begin
            st_we           = 4'b0001 << alu_result[1:0];
            data_sram_wdata = {4{st_data[7:0]}};
        end else if (st_op[1]) begin
            st_we           = 4'b0011 << {alu_result[1], 1'b0};
            data_sram_wdata = {2{st_data[15:0]}};
        end else if (st_op[0]) begin
            st_we           = 4'b1111;
        end
    end

    assign data_sram_en   = sram_go;
    assign data_sram_we   = sram_go ? st_we : 4'b0000;
    assign data_sram_addr = alu_result;

endmodule

// File: tb/tb_exe_stage_div.sv
// Self-checking bench for exe_stage_div: directed vector table, hand-written
// corner sequences (stall, flush, back-to-back divides) and random instructions
// compared against an arithmetic reference model. Honours DIV_ZERO_FAST_EN.
module tb_exe_stage_div;

`ifdef DIV_ZERO_FAST_EN
    localparam int DZ_LAT = 2;
`else
    localparam int DZ_LAT = 34;
`endif
    localparam logic [11:0] ADD = 12'h001;
    localparam logic [11:0] SUB = 12'h002;

    logic        clk = 1'b0;
    logic        reset;
    logic        es_allowin;
    logic        ds2es_valid;
    logic [31:0] ds_pc, ds_src1, ds_src2, ds_st_data;
    logic [11:0] ds_alu_op;
    logic [3:0]  ds_div_op;
    logic [4:0]  ds_ld_op;
    logic [2:0]  ds_st_op;
    logic [6:0]  ds_rf_ctl, ds_except_zip;
    logic [31:0] es_src1, es_src2;
    logic [11:0] es_alu_op;
    logic [31:0] alu_result;
    logic        ms_allowin;
    logic        es2ms_valid;
    logic [4:0]  es2ms_ld_op;
    logic [31:0] es2ms_pc;
    logic [6:0]  es2ms_except;
    logic [39:0] es_rf_zip;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        ms_ex, wb_ex;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] pc_ctr = 32'h1c00_0000;

    typedef struct {
        logic [31:0] pc;
        logic [11:0] alu_op;
        logic [3:0]  div_op;
        logic [4:0]  ld_op;
        logic [2:0]  st_op;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] st_data;
    } instr_t;

    typedef struct {
        int          lat;
        logic [31:0] rf_wdata;
        logic        en;
        logic [3:0]  we;
        logic [31:0] sram_wdata;
        logic        ale;
    } exp_t;

    typedef struct {
        instr_t in;
        exp_t   ex;
    } vec_t;

    always #5 clk = ~clk;

    exe_stage_div dut (
        .clk(clk), .reset(reset), .es_allowin(es_allowin), .ds2es_valid(ds2es_valid),
        .ds_pc(ds_pc), .ds_src1(ds_src1), .ds_src2(ds_src2), .ds_alu_op(ds_alu_op),
        .ds_div_op(ds_div_op), .ds_ld_op(ds_ld_op), .ds_st_op(ds_st_op),
        .ds_rf_ctl(ds_rf_ctl), .ds_st_data(ds_st_data), .ds_except_zip(ds_except_zip),
        .es_src1(es_src1), .es_src2(es_src2), .es_alu_op(es_alu_op),
        .alu_result(alu_result), .ms_allowin(ms_allowin), .es2ms_valid(es2ms_valid),
        .es2ms_ld_op(es2ms_ld_op), .es2ms_pc(es2ms_pc), .es2ms_except(es2ms_except),
        .es_rf_zip(es_rf_zip), .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .ms_ex(ms_ex), .wb_ex(wb_ex)
    );

    // Stand-in for the sibling ALU.
    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [11:0] op);
        if (op[0]) return a + b;
        if (op[1]) return a - b;
        if (op[2]) return a & b;
        return a ^ b;
    endfunction

    assign alu_result = alu_f(es_src1, es_src2, es_alu_op);

    function automatic instr_t mk(input logic [11:0] alu, input logic [3:0] dv,
                                  input logic [4:0] ld, input logic [2:0] st,
                                  input logic [31:0] s1, input logic [31:0] s2,
                                  input logic [31:0] sd);
        instr_t t;
        t.pc = 32'd0; t.alu_op = alu; t.div_op = dv; t.ld_op = ld; t.st_op = st;
        t.src1 = s1; t.src2 = s2; t.st_data = sd;
        return t;
    endfunction

    function automatic exp_t ex(input int lat, input logic [31:0] rf, input logic en,
                                input logic [3:0] we, input logic [31:0] wd, input logic ale);
        exp_t e;
        e.lat = lat; e.rf_wdata = rf; e.en = en; e.we = we; e.sram_wdata = wd; e.ale = ale;
        return e;
    endfunction

    // Reference model: plain arithmetic division and the addressing rules.
    function automatic exp_t model(input instr_t t);
        exp_t        e;
        logic [31:0] a, q, r;
        logic [1:0]  lo;
        longint      sa, sb;
        a = alu_f(t.src1, t.src2, t.alu_op);
        e.lat = 1; e.rf_wdata = a; e.en = 1'b0; e.we = 4'b0; e.sram_wdata = 32'd0;
        if (t.div_op != 4'b0) begin
            if (t.src2 == 32'd0) begin
                q = 32'hFFFF_FFFF; r = t.src1; e.lat = DZ_LAT;
            end else begin
                e.lat = 34;
                if (t.div_op[3] | t.div_op[1]) begin
                    sa = longint'($signed(t.src1));
                    sb = longint'($signed(t.src2));
                    q = 32'(sa / sb);
                    r = 32'(sa % sb);
                end else begin
                    q = t.src1 / t.src2;
                    r = t.src1 % t.src2;
                end
            end
            e.rf_wdata = (t.div_op[3] | t.div_op[2]) ? q : r;
        end
        lo = a[1:0];
        e.ale = ((t.ld_op[2] | t.ld_op[1] | t.st_op[1]) && lo[0]) ||
                ((t.ld_op[0] | t.st_op[0]) && lo != 2'b00);
        e.en = ((t.ld_op != 5'b0) || (t.st_op != 3'b0)) && !e.ale;
        if (e.en) begin
            if (t.st_op[2]) begin
                e.we = 4'b0001 << lo; e.sram_wdata = {4{t.st_data[7:0]}};
            end else if (t.st_op[1]) begin
                e.we = 4'b0011 << {lo[1], 1'b0}; e.sram_wdata = {2{t.st_data[15:0]}};
            end else if (t.st_op[0]) begin
                e.we = 4'hF; e.sram_wdata = t.st_data;
            end
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input instr_t t);
        ds2es_valid   = 1'b1;
        ds_pc         = t.pc;
        ds_src1       = t.src1;
        ds_src2       = t.src2;
        ds_alu_op     = t.alu_op;
        ds_div_op     = t.div_op;
        ds_ld_op      = t.ld_op;
        ds_st_op      = t.st_op;
        ds_rf_ctl     = 7'b0100101;
        ds_st_data    = t.st_data;
        ds_except_zip = 7'd0;
    endtask

    // Called on the cycle the instruction is being latched; waits for its handoff.
    task automatic collect(input instr_t t, input exp_t e, input bit chain,
                           input instr_t nxt, input string tag);
        int lat;
        bit allow_bad;
        lat = 1;
        allow_bad = 1'b0;
        @(negedge clk);
        if (chain) drive(nxt);
        else ds2es_valid = 1'b0;
        #1;
        while (!es2ms_valid && lat < 100) begin
            if (es_allowin) allow_bad = 1'b1;
            @(negedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, lat, e.lat);
        if (e.lat > 1) check({tag, " allowin_busy"}, allow_bad, 1'b0);
        check({tag, " rf_wdata"}, es_rf_zip[31:0], e.rf_wdata);
        check({tag, " rf_ctl"}, es_rf_zip[39:32], {1'b0, |t.ld_op, 1'b1, 5'd5});
        check({tag, " pc"}, es2ms_pc, t.pc);
        check({tag, " ld_op"}, es2ms_ld_op, t.ld_op);
        check({tag, " sram_en"}, data_sram_en, e.en);
        check({tag, " sram_we"}, data_sram_we, e.we);
        check({tag, " ale"}, es2ms_except[6], e.ale);
        if (e.en) check({tag, " sram_addr"}, data_sram_addr, e.rf_wdata);
        if (e.en && t.st_op != 3'b0) check({tag, " sram_wdata"}, data_sram_wdata, e.sram_wdata);
        if (chain) check({tag, " allowin_handoff"}, es_allowin, 1'b1);
    endtask

    task automatic run_instr(input instr_t t, input exp_t e, input string tag);
        int w;
        w = 0;
        @(negedge clk);
        t.pc = pc_ctr;
        pc_ctr += 4;
        drive(t);
        ms_allowin = 1'b1;
        #1;
        while (!es_allowin && w < 100) begin
            @(negedge clk);
            #1;
            w++;
        end
        check({tag, " allowin"}, es_allowin, 1'b1);
        collect(t, e, 1'b0, t, tag);
    endtask

    vec_t   vecs[18];
    instr_t t, t2;
    int     req, seen;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; ds2es_valid = 1'b0; ds_pc = '0; ds_src1 = '0; ds_src2 = '0;
        ds_alu_op = '0; ds_div_op = '0; ds_ld_op = '0; ds_st_op = '0; ds_rf_ctl = '0;
        ds_st_data = '0; ds_except_zip = '0; ms_allowin = 1'b1; ms_ex = 1'b0; wb_ex = 1'b0;

        vecs[0]  = '{mk(ADD, 4'b0000, 5'b0, 3'b0, 32'd5, 32'd7, 0), ex(1, 32'd12, 0, 0, 0, 0)};
        vecs[1]  = '{mk(ADD, 4'b1000, 5'b0, 3'b0, 32'hFFFF_FFF9, 32'd2, 0), ex(34, 32'hFFFF_FFFD, 0, 0, 0, 0)};
        vecs[2]  = '{mk(ADD, 4'b0010, 5'b0, 3'b0, 32'hFFFF_FFF9, 32'd2, 0), ex(34, 32'hFFFF_FFFF, 0, 0, 0, 0)};
        vecs[3]  = '{mk(ADD, 4'b0100, 5'b0, 3'b0, 32'h8000_0000, 32'd0, 0), ex(DZ_LAT, 32'hFFFF_FFFF, 0, 0, 0, 0)};
        vecs[4]  = '{mk(ADD, 4'b0001, 5'b0, 3'b0, 32'h8000_0000, 32'd0, 0), ex(DZ_LAT, 32'h8000_0000, 0, 0, 0, 0)};
        vecs[5]  = '{mk(ADD, 4'b0, 5'b0, 3'b010, 32'h1000, 32'd2, 32'hABCD_1234), ex(1, 32'h1002, 1, 4'b1100, 32'h1234_1234, 0)};
        vecs[6]  = '{mk(ADD, 4'b0, 5'b0, 3'b010, 32'h1000, 32'd3, 32'hABCD_1234), ex(1, 32'h1003, 0, 4'b0000, 0, 1)};
        vecs[7]  = '{mk(ADD, 4'b0, 5'b0, 3'b100, 32'h1000, 32'd1, 32'h0000_00A5), ex(1, 32'h1001, 1, 4'b0010, 32'hA5A5_A5A5, 0)};
        vecs[8]  = '{mk(ADD, 4'b0, 5'b0, 3'b001, 32'h1000, 32'd4, 32'hDEAD_BEEF), ex(1, 32'h1004, 1, 4'b1111, 32'hDEAD_BEEF, 0)};
        vecs[9]  = '{mk(ADD, 4'b0, 5'b00001, 3'b0, 32'h1000, 32'd6, 0), ex(1, 32'h1006, 0, 0, 0, 1)};
        vecs[10] = '{mk(ADD, 4'b0, 5'b00010, 3'b0, 32'h2000, 32'd2, 0), ex(1, 32'h2002, 1, 0, 0, 0)};
        vecs[11] = '{mk(ADD, 4'b1000, 5'b0, 3'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0), ex(34, 32'h8000_0000, 0, 0, 0, 0)};
        vecs[12] = '{mk(ADD, 4'b0010, 5'b0, 3'b0, 32'd7, 32'hFFFF_FFFE, 0), ex(34, 32'd1, 0, 0, 0, 0)};
        vecs[13] = '{mk(ADD, 4'b0100, 5'b0, 3'b0, 32'hFFFF_FFFF, 32'd3, 0), ex(34, 32'h5555_5555, 0, 0, 0, 0)};
        vecs[14] = '{mk(SUB, 4'b0, 5'b0, 3'b0, 32'd3, 32'd5, 0), ex(1, 32'hFFFF_FFFE, 0, 0, 0, 0)};
        vecs[15] = '{mk(ADD, 4'b1000, 5'b0, 3'b0, 32'hFFFF_FFF9, 32'd0, 0), ex(DZ_LAT, 32'hFFFF_FFFF, 0, 0, 0, 0)};
        vecs[16] = '{mk(ADD, 4'b0010, 5'b0, 3'b0, 32'hFFFF_FFF9, 32'd0, 0), ex(DZ_LAT, 32'hFFFF_FFF9, 0, 0, 0, 0)};
        vecs[17] = '{mk(ADD, 4'b0, 5'b10000, 3'b0, 32'h1000, 32'd3, 0), ex(1, 32'h1003, 1, 0, 0, 0)};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset es2ms_valid", es2ms_valid, 1'b0);
        check("reset sram_en", data_sram_en, 1'b0);
        check("reset sram_we", data_sram_we, 4'b0);
        check("reset es_allowin", es_allowin, 1'b1);
        check("reset rf_zip", es_rf_zip, 40'd0);
        check("reset pc", es2ms_pc, 32'd0);

        // Directed vector table
        for (int i = 0; i < 18; i++) begin
            run_instr(vecs[i].in, vecs[i].ex, $sformatf("vec%0d", i));
        end

        // Store held by a 3-cycle MEM stall issues exactly one request
        @(negedge clk);
        t = mk(ADD, 4'b0, 5'b0, 3'b001, 32'h3000, 32'd8, 32'h1122_3344);
        t.pc = pc_ctr; pc_ctr += 4;
        drive(t);
        ms_allowin = 1'b0;
        req = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) ds2es_valid = 1'b0;
            ms_allowin = (c == 4);
            #1;
            if (data_sram_en) req++;
            if (c < 4) check($sformatf("stall valid c%0d", c), es2ms_valid, 1'b1);
            if (c == 4) check("stall we", data_sram_we, 4'hF);
        end
        check("stall request count", req, 1);

        // MEM-stage exception suppresses the store
        @(negedge clk);
        t = mk(ADD, 4'b0, 5'b0, 3'b001, 32'h3000, 32'd4, 32'h5566_7788);
        t.pc = pc_ctr; pc_ctr += 4;
        drive(t);
        ms_allowin = 1'b1;
        @(negedge clk);
        ds2es_valid = 1'b0;
        ms_ex = 1'b1;
        #1;
        check("ms_ex valid", es2ms_valid, 1'b1);
        check("ms_ex sram_en", data_sram_en, 1'b0);
        check("ms_ex sram_we", data_sram_we, 4'b0);
        @(negedge clk);
        ms_ex = 1'b0;

        // Upstream exception blocks the load and is forwarded
        t = mk(ADD, 4'b0, 5'b00001, 3'b0, 32'h1000, 32'd4, 0);
        t.pc = pc_ctr; pc_ctr += 4;
        drive(t);
        ds_except_zip = 7'h01;
        @(negedge clk);
        ds2es_valid = 1'b0;
        ds_except_zip = 7'h00;
        #1;
        check("exc valid", es2ms_valid, 1'b1);
        check("exc sram_en", data_sram_en, 1'b0);
        check("exc except", es2ms_except, 7'h01);

        // WB flush at CALC iteration 10 aborts the divide
        @(negedge clk);
        t = mk(ADD, 4'b0100, 5'b0, 3'b0, 32'd100, 32'd7, 0);
        t.pc = pc_ctr; pc_ctr += 4;
        drive(t);
        @(negedge clk);
        ds2es_valid = 1'b0;
        repeat (11) @(negedge clk);
        wb_ex = 1'b1;
        #1;
        check("flush busy", es2ms_valid, 1'b0);
        @(negedge clk);
        wb_ex = 1'b0;
        #1;
        check("flush allowin", es_allowin, 1'b1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (es2ms_valid) seen++;
        end
        check("flush no writeback", seen, 0);
        t = mk(ADD, 4'b1000, 5'b0, 3'b0, 32'd100, 32'hFFFF_FFF9, 0);
        run_instr(t, model(t), "post_flush");

        // Back-to-back divides: second is latched on the first's handoff
        @(negedge clk);
        t = mk(ADD, 4'b1000, 5'b0, 3'b0, 32'd100, 32'hFFFF_FFF9, 0);
        t.pc = pc_ctr; pc_ctr += 4;
        t2 = mk(ADD, 4'b0001, 5'b0, 3'b0, 32'd100, 32'd7, 0);
        t2.pc = pc_ctr; pc_ctr += 4;
        drive(t);
        ms_allowin = 1'b1;
        collect(t, model(t), 1'b1, t2, "b2b_a");
        collect(t2, model(t2), 1'b0, t2, "b2b_b");

        // Random instructions against the reference model
        for (int i = 0; i < 80; i++) begin
            t = mk(ADD, 4'b0, 5'b0, 3'b0, $urandom, $urandom, $urandom);
            case ($urandom_range(0, 3))
                0: begin
                    t.div_op = 4'b0001 << $urandom_range(0, 3);
                    case ($urandom_range(0, 3))
                        0: t.src2 = 32'd0;
                        1: t.src2 = $urandom_range(1, 20);
                        2: t.src2 = -$urandom_range(1, 20);
                        default: t.src2 = $urandom;
                    endcase
                end
                1: t.alu_op = 12'h001 << $urandom_range(0, 3);
                2: begin
                    t.st_op = 3'b001 << $urandom_range(0, 2);
                    t.src1 = $urandom & 32'h0000_FFF0;
                    t.src2 = $urandom_range(0, 7);
                end
                default: begin
                    t.ld_op = 5'b00001 << $urandom_range(0, 4);
                    t.src1 = $urandom & 32'h0000_FFF0;
                    t.src2 = $urandom_range(0, 7);
                end
            endcase
            run_instr(t, model(t), $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
